filt_frame_scheduler: RTL and testbench

//  Owns the two disparity frame buffers (index 0/1) shared by the block-matching producer,
//  the multi-pass filter engine (start/index_in/idle) and the downstream readout consumer.

---
 rtl/filt_pkg.sv | 16 +
 rtl/filt_buf_alloc.sv | 23 ++
 rtl/filt_frame_scheduler.sv | 156 +++++++++++++++
 tb/tb_filt_frame_scheduler.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/filt_pkg.sv
// Shared types and constants for the disparity frame-buffer scheduler.
package filt_pkg;

    typedef enum logic [2:0] {
        FREE = 3'd0,
        FILL = 3'd1,
        PEND = 3'd2,
        FILT = 3'd3,
        READ = 3'd4
    } buf_state_t;

    localparam int BUF_IDX_W      = 1;
    localparam int NUM_BUF_FIXED  = 2;
    localparam int STAT_W_DEFAULT = 16;

endpackage

// File: rtl/filt_buf_alloc.sv
// Lowest-index search over the buffer state table for one target state.
module filt_buf_alloc
    import filt_pkg::*;
(
    input  buf_state_t             states [NUM_BUF_FIXED],
    input  buf_state_t             target,
    output logic                   found,
    output logic [BUF_IDX_W-1:0]   idx
);

    // Scan from the top down so the lowest matching index is the one kept.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = NUM_BUF_FIXED - 1; i >= 0; i--) begin
            if (states[i] == target) begin
                found = 1'b1;
                idx   = i[BUF_IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/filt_frame_scheduler.sv
// Ping-pong ownership scheduler for the two disparity frame buffers shared by
// the block-matching producer, the filter engine and the readout consumer.
// Optional statistics counters are built when FILT_FRAME_STATS_EN is defined.
module filt_frame_scheduler
    import filt_pkg::*;
#(
    parameter int NUM_BUF = 2,
    parameter int STAT_W  = STAT_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 prod_frame_start,
    input  logic                 prod_frame_done,
    output logic                 prod_ena,
    output logic [BUF_IDX_W-1:0] prod_index,
    output logic                 prod_drop,
    output logic                 filt_start,
    output logic [BUF_IDX_W-1:0] filt_index,
    input  logic                 filt_idle,
    output logic                 cons_valid,
    output logic [BUF_IDX_W-1:0] cons_index,
    input  logic                 cons_done,
    output logic [STAT_W-1:0]    drop_cnt,
    output logic [STAT_W-1:0]    filt_cnt
);

    if (NUM_BUF != NUM_BUF_FIXED) begin : g_num_buf_check
        $error("filt_frame_scheduler supports exactly two buffers");
    end

    buf_state_t                 st   [NUM_BUF_FIXED];
    buf_state_t                 st_n [NUM_BUF_FIXED];
    logic                       guard, guard_n;
    logic                       prod_ena_n, prod_drop_n, filt_start_n, cons_valid_n;
    logic [BUF_IDX_W-1:0]       prod_index_n, filt_index_n, cons_index_n;
    logic                       dispatch, complete, overwrite;

    logic                       free_found, pend_found, fill_found, filt_found, read_found;
    logic [BUF_IDX_W-1:0]       free_idx, pend_idx, fill_idx, filt_idx, read_idx;

    filt_buf_alloc u_find_free (.states(st), .target(FREE), .found(free_found), .idx(free_idx));
    filt_buf_alloc u_find_pend (.states(st), .target(PEND), .found(pend_found), .idx(pend_idx));
    filt_buf_alloc u_find_fill (.states(st), .target(FILL), .found(fill_found), .idx(fill_idx));
    filt_buf_alloc u_find_filt (.states(st), .target(FILT), .found(filt_found), .idx(filt_idx));
    filt_buf_alloc u_find_read (.states(st), .target(READ), .found(read_found), .idx(read_idx));

    // Next-state and next-output decisions, all taken from the registered state.
    always_comb begin
        st_n         = st;
        guard_n      = guard;
        prod_ena_n   = prod_ena;
        prod_index_n = prod_index;
        prod_drop_n  = 1'b0;
        filt_start_n = 1'b0;
        filt_index_n = filt_index;
        cons_valid_n = cons_valid;
        cons_index_n = cons_index;
        overwrite    = 1'b0;

        // The engine only reports busy a cycle after start; hold off completion
        // until that low idle has actually been observed.
        if (guard && !filt_idle) guard_n = 1'b0;

        dispatch = pend_found && !filt_found && filt_idle && !guard;
        if (dispatch) begin
            st_n[pend_idx] = FILT;
            filt_start_n   = 1'b1;
            filt_index_n   = pend_idx;
            guard_n        = 1'b1;
        end

        // A finished buffer waits in FILT while the consumer still owns the
        // other one, so two READ buffers never coexist.
        complete = filt_found && !guard && filt_idle && !read_found;
        if (complete) begin
            st_n[filt_idx] = READ;
            cons_valid_n   = 1'b1;
            cons_index_n   = filt_idx;
        end

        // A PEND buffer being dispatched this cycle cannot also be overwritten.
        if (prod_frame_start) begin
            if (fill_found) begin
                prod_ena_n   = 1'b1;
                prod_index_n = fill_idx;
            end else if (free_found) begin
                st_n[free_idx] = FILL;
                prod_ena_n     = 1'b1;
                prod_index_n   = free_idx;
            end else if (pend_found && !dispatch) begin
                st_n[pend_idx] = FILL;
                prod_ena_n     = 1'b1;
                prod_index_n   = pend_idx;
                overwrite      = 1'b1;
            end else begin
                prod_drop_n = 1'b1;
            end
        end

        if (prod_frame_done && fill_found) begin
            st_n[fill_idx] = PEND;
            prod_ena_n     = 1'b0;
        end

        if (cons_done && cons_valid) begin
            st_n[read_idx] = FREE;
            cons_valid_n   = 1'b0;
        end
    end

    // State table, guard flag and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st         <= '{default: FREE};
            guard      <= 1'b0;
            prod_ena   <= 1'b0;
            prod_index <= '0;
            prod_drop  <= 1'b0;
            filt_start <= 1'b0;
            filt_index <= '0;
            cons_valid <= 1'b0;
            cons_index <= '0;
        end else begin
            st         <= st_n;
            guard      <= guard_n;
            prod_ena   <= prod_ena_n;
            prod_index <= prod_index_n;
            prod_drop  <= prod_drop_n;
            filt_start <= filt_start_n;
            filt_index <= filt_index_n;
            cons_valid <= cons_valid_n;
            cons_index <= cons_index_n;
        end
    end

`ifdef FILT_FRAME_STATS_EN
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Saturating drop and filtered-frame counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt <= '0;
            filt_cnt <= '0;
        end else begin
            if (prod_drop_n || overwrite) drop_cnt <= sat_inc(drop_cnt);
            if (complete)                 filt_cnt <= sat_inc(filt_cnt);
        end
    end
`else
    assign drop_cnt = '0;
    assign filt_cnt = '0;
`endif

endmodule

// File: tb/tb_filt_frame_scheduler.sv
// Directed self-checking bench for filt_frame_scheduler.
module tb_filt_frame_scheduler;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        prod_frame_start, prod_frame_done, filt_idle, cons_done;
    logic        prod_ena, prod_index, prod_drop, filt_start, filt_index, cons_valid, cons_index;
    logic [15:0] drop_cnt, filt_cnt;
    logic [15:0] exp_cnt;
    int          vectors = 0;
    int          miscompares = 0;

    filt_frame_scheduler dut (
        .clk(clk), .reset_n(reset_n),
        .prod_frame_start(prod_frame_start), .prod_frame_done(prod_frame_done),
        .prod_ena(prod_ena), .prod_index(prod_index), .prod_drop(prod_drop),
        .filt_start(filt_start), .filt_index(filt_index), .filt_idle(filt_idle),
        .cons_valid(cons_valid), .cons_index(cons_index), .cons_done(cons_done),
        .drop_cnt(drop_cnt), .filt_cnt(filt_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        prod_frame_start = 1'b0; prod_frame_done = 1'b0; cons_done = 1'b0; filt_idle = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++; if (prod_ena !== 1'b0)   begin $display("FAIL rst_prod_ena: got %b want 0", prod_ena); miscompares++; end
        vectors++; if (prod_drop !== 1'b0)  begin $display("FAIL rst_prod_drop: got %b want 0", prod_drop); miscompares++; end
        vectors++; if (filt_start !== 1'b0) begin $display("FAIL rst_filt_start: got %b want 0", filt_start); miscompares++; end
        vectors++; if (cons_valid !== 1'b0) begin $display("FAIL rst_cons_valid: got %b want 0", cons_valid); miscompares++; end
        vectors++; if (drop_cnt !== 16'd0)  begin $display("FAIL rst_drop_cnt: got %0d want 0", drop_cnt); miscompares++; end
        vectors++; if (filt_cnt !== 16'd0)  begin $display("FAIL rst_filt_cnt: got %0d want 0", filt_cnt); miscompares++; end
    endtask

    task automatic test_basic_flow();
        apply_reset();
        prod_frame_start = 1'b1; step(); prod_frame_start = 1'b0;
        vectors++; if (prod_ena !== 1'b1)   begin $display("FAIL t1_grant_ena: got %b want 1", prod_ena); miscompares++; end
        vectors++; if (prod_index !== 1'b0) begin $display("FAIL t1_grant_idx: got %b want 0", prod_index); miscompares++; end
        prod_frame_done = 1'b1; step(); prod_frame_done = 1'b0;
        vectors++; if (prod_ena !== 1'b0)   begin $display("FAIL t1_done_ena: got %b want 0", prod_ena); miscompares++; end
        vectors++; if (filt_start !== 1'b0) begin $display("FAIL t1_start_early: got %b want 0", filt_start); miscompares++; end
        step();
        vectors++; if (filt_start !== 1'b1) begin $display("FAIL t1_filt_start: got %b want 1", filt_start); miscompares++; end
        vectors++; if (filt_index !== 1'b0) begin $display("FAIL t1_filt_index: got %b want 0", filt_index); miscompares++; end
        step();
        vectors++; if (filt_start !== 1'b0) begin $display("FAIL t1_start_pulse: got %b want 0", filt_start); miscompares++; end
        filt_idle = 1'b0; step();
        vectors++; if (cons_valid !== 1'b0) begin $display("FAIL t1_busy_valid: got %b want 0", cons_valid); miscompares++; end
        filt_idle = 1'b1; step();
        vectors++; if (cons_valid !== 1'b1) begin $display("FAIL t1_cons_valid: got %b want 1", cons_valid); miscompares++; end
        vectors++; if (cons_index !== 1'b0) begin $display("FAIL t1_cons_index: got %b want 0", cons_index); miscompares++; end
`ifdef FILT_FRAME_STATS_EN
        exp_cnt = 16'd1;
`else
        exp_cnt = 16'd0;
`endif
        vectors++; if (filt_cnt !== exp_cnt) begin $display("FAIL t1_filt_cnt: got %0d want %0d", filt_cnt, exp_cnt); miscompares++; end
    endtask

    task automatic test_guard();
        apply_reset();
        prod_frame_start = 1'b1; step(); prod_frame_start = 1'b0;
        prod_frame_done = 1'b1;  step(); prod_frame_done = 1'b0;
        step();
        vectors++; if (filt_start !== 1'b1) begin $display("FAIL t6_filt_start: got %b want 1", filt_start); miscompares++; end
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++; if (cons_valid !== 1'b0) begin $display("FAIL t6_premature_read: got %b want 0", cons_valid); miscompares++; end
        end
        filt_idle = 1'b0; step();
        vectors++; if (cons_valid !== 1'b0) begin $display("FAIL t6_busy_valid: got %b want 0", cons_valid); miscompares++; end
        filt_idle = 1'b1; step();
        vectors++; if (cons_valid !== 1'b1) begin $display("FAIL t6_cons_valid: got %b want 1", cons_valid); miscompares++; end
    endtask

    task automatic test_overwrite();
        apply_reset();
        prod_frame_start = 1'b1; step(); prod_frame_start = 1'b0;
        prod_frame_done = 1'b1;  step(); prod_frame_done = 1'b0;
        step();
        vectors++; if (filt_start !== 1'b1) begin $display("FAIL t2_filt_start0: got %b want 1", filt_start); miscompares++; end
        filt_idle = 1'b0; step();
        prod_frame_start = 1'b1; step(); prod_frame_start = 1'b0;
        vectors++; if (prod_index !== 1'b1) begin $display("FAIL t2_second_idx: got %b want 1", prod_index); miscompares++; end
        prod_frame_done = 1'b1;  step(); prod_frame_done = 1'b0;
        vectors++; if (prod_ena !== 1'b0)   begin $display("FAIL t2_second_done: got %b want 0", prod_ena); miscompares++; end
        prod_frame_start = 1'b1; step(); prod_frame_start = 1'b0;
        vectors++; if (prod_ena !== 1'b1)   begin $display("FAIL t2_ovw_ena: got %b want 1", prod_ena); miscompares++; end
        vectors++; if (prod_index !== 1'b1) begin $display("FAIL t2_ovw_idx: got %b want 1", prod_index); miscompares++; end
        vectors++; if (prod_drop !== 1'b0)  begin $display("FAIL t2_ovw_drop: got %b want 0", prod_drop); miscompares++; end
`ifdef FILT_FRAME_STATS_EN
        exp_cnt = 16'd1;
`else
        exp_cnt = 16'd0;
`endif
        vectors++; if (drop_cnt !== exp_cnt) begin $display("FAIL t2_drop_cnt: got %0d want %0d", drop_cnt, exp_cnt); miscompares++; end
        prod_frame_done = 1'b1; step(); prod_frame_done = 1'b0;
        filt_idle = 1'b1; step();
        vectors++; if (cons_valid !== 1'b1) begin $display("FAIL t2_read0_valid: got %b want 1", cons_valid); miscompares++; end
        vectors++; if (cons_index !== 1'b0) begin $display("FAIL t2_read0_idx: got %b want 0", cons_index); miscompares++; end
        step();
        vectors++; if (filt_start !== 1'b1) begin $display("FAIL t2_filt_start1: got %b want 1", filt_start); miscompares++; end
        vectors++; if (filt_index !== 1'b1) begin $display("FAIL t2_filt_index1: got %b want 1", filt_index); miscompares++; end
        filt_idle = 1'b0; step();
    endtask

    task automatic test_drop();
        prod_frame_start = 1'b1; step(); prod_frame_start = 1'b0;
        vectors++; if (prod_drop !== 1'b1) begin $display("FAIL t3_drop: got %b want 1", prod_drop); miscompares++; end
        vectors++; if (prod_ena !== 1'b0)  begin $display("FAIL t3_ena: got %b want 0", prod_ena); miscompares++; end
`ifdef FILT_FRAME_STATS_EN
        exp_cnt = 16'd2;
`else
        exp_cnt = 16'd0;
`endif
        vectors++; if (drop_cnt !== exp_cnt) begin $display("FAIL t3_drop_cnt: got %0d want %0d", drop_cnt, exp_cnt); miscompares++; end
        step();
        vectors++; if (prod_drop !== 1'b0) begin $display("FAIL t3_drop_pulse: got %b want 0", prod_drop); miscompares++; end
        filt_idle = 1'b1; step(); step();
        vectors++; if (cons_index !== 1'b0) begin $display("FAIL t3_read_held: got %b want 0", cons_index); miscompares++; end
        vectors++; if (cons_valid !== 1'b1) begin $display("FAIL t3_valid_held: got %b want 1", cons_valid); miscompares++; end
        vectors++; if (filt_start !== 1'b0) begin $display("FAIL t3_no_start: got %b want 0", filt_start); miscompares++; end
        filt_idle = 1'b0; step();
    endtask

    task automatic test_same_cycle();
        cons_done = 1'b1; prod_frame_start = 1'b1; step();
        cons_done = 1'b0; prod_frame_start = 1'b0;
        vectors++; if (prod_drop !== 1'b1)  begin $display("FAIL t4_drop: got %b want 1", prod_drop); miscompares++; end
        vectors++; if (cons_valid !== 1'b0) begin $display("FAIL t4_released: got %b want 0", cons_valid); miscompares++; end
        vectors++; if (prod_ena !== 1'b0)   begin $display("FAIL t4_ena: got %b want 0", prod_ena); miscompares++; end
        cons_done = 1'b1; step(); cons_done = 1'b0;
        vectors++; if (cons_valid !== 1'b0) begin $display("FAIL t4_done_ignored: got %b want 0", cons_valid); miscompares++; end
        prod_frame_start = 1'b1; step(); prod_frame_start = 1'b0;
        vectors++; if (prod_ena !== 1'b1)   begin $display("FAIL t4_regrant_ena: got %b want 1", prod_ena); miscompares++; end
        vectors++; if (prod_index !== 1'b0) begin $display("FAIL t4_regrant_idx: got %b want 0", prod_index); miscompares++; end
        filt_idle = 1'b1; step();
        vectors++; if (cons_valid !== 1'b1) begin $display("FAIL t4_read1_valid: got %b want 1", cons_valid); miscompares++; end
        vectors++; if (cons_index !== 1'b1) begin $display("FAIL t4_read1_idx: got %b want 1", cons_index); miscompares++; end
`ifdef FILT_FRAME_STATS_EN
        exp_cnt = 16'd2;
`else
        exp_cnt = 16'd0;
`endif
        vectors++; if (filt_cnt !== exp_cnt) begin $display("FAIL t4_filt_cnt: got %0d want %0d", filt_cnt, exp_cnt); miscompares++; end
    endtask

    task automatic test_async_reset();
        apply_reset();
        prod_frame_start = 1'b1; step(); prod_frame_start = 1'b0;
        prod_frame_done = 1'b1;  step(); prod_frame_done = 1'b0;
        prod_frame_start = 1'b1; step(); prod_frame_start = 1'b0;
        vectors++; if (filt_start !== 1'b1) begin $display("FAIL t5_pre_start: got %b want 1", filt_start); miscompares++; end
        vectors++; if (prod_index !== 1'b1) begin $display("FAIL t5_pre_idx: got %b want 1", prod_index); miscompares++; end
        #2 reset_n = 1'b0;
        #1;
        vectors++; if (filt_start !== 1'b0) begin $display("FAIL t5_async_start: got %b want 0", filt_start); miscompares++; end
        vectors++; if (prod_ena !== 1'b0)   begin $display("FAIL t5_async_ena: got %b want 0", prod_ena); miscompares++; end
        vectors++; if (prod_index !== 1'b0) begin $display("FAIL t5_async_idx: got %b want 0", prod_index); miscompares++; end
        #2 reset_n = 1'b1;
        prod_frame_start = 1'b1; step(); prod_frame_start = 1'b0;
        vectors++; if (prod_ena !== 1'b1)   begin $display("FAIL t5_post_ena: got %b want 1", prod_ena); miscompares++; end
        vectors++; if (prod_index !== 1'b0) begin $display("FAIL t5_post_idx: got %b want 0", prod_index); miscompares++; end
    endtask

    initial begin
        test_reset();
        test_basic_flow();
        test_guard();
        test_overwrite();
        test_drop();
        test_same_cycle();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
